// File: rtl/instr_pkg.sv
// Shared instruction and response types for the NMCU host interface.
package instr_pkg;

  parameter int PSUM_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_MATMUL = 3'd3
  } opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [15:0] addr_a;
    logic [15:0] addr_b;
    logic [15:0] addr_c;
    logic [7:0]  dim_n;
    logic [7:0]  dim_m;
    logic [7:0]  dim_k;
    logic [31:0] data;
  } instruction_t;

  typedef struct packed {
    logic [PSUM_WIDTH-1:0] data;
    logic [1:0]            status;
  } nmcu_cpu_resp_t;

endpackage

// File: rtl/nmcu_instr_dispatcher.sv
// Host-side instruction FIFO and single-outstanding issuer for the NMCU, returning tagged responses in order.
// Optional response watchdog in WAIT_RESP is enabled by defining NMCU_DISP_TIMEOUT_EN.
module nmcu_instr_dispatcher #(
  parameter int DEPTH          = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           host_instr_valid_i,
  input  instr_pkg::instruction_t        host_instr_i,
  output logic                           host_instr_ready_o,
  output logic                           host_resp_valid_o,
  input  logic                           host_resp_ready_i,
  output instr_pkg::nmcu_cpu_resp_t      host_resp_o,
  output logic [TAG_WIDTH-1:0]           host_resp_tag_o,
  output logic                           nmcu_instr_valid_o,
  output instr_pkg::instruction_t        nmcu_instruction_o,
  input  logic                           nmcu_instr_ready_i,
  input  logic                           nmcu_resp_valid_i,
  output logic                           nmcu_resp_ready_o,
  input  instr_pkg::nmcu_cpu_resp_t      nmcu_response_i,
  output logic                           busy_o,
  output logic [$clog2(DEPTH+1)-1:0]     queue_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_RETURN    = 2'd3
  } state_t;

  typedef struct packed {
    instr_pkg::instruction_t instr;
    logic [TAG_WIDTH-1:0]    tag;
  } entry_t;

  entry_t                    r_mem [DEPTH];
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [TAG_WIDTH-1:0]      r_tag_cnt;
  state_t                    r_state;
  state_t                    w_state_nxt;
  instr_pkg::instruction_t   r_issue_instr;
  logic [TAG_WIDTH-1:0]      r_issue_tag;
  instr_pkg::nmcu_cpu_resp_t r_resp;
  logic [TAG_WIDTH-1:0]      r_resp_tag;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_capture;
  logic w_to_fire;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // Ready looks only at full, so a pop in the same cycle never lets a push through.
  assign w_push  = host_instr_valid_i && !w_full;

`ifdef NMCU_DISP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] r_to_cnt;
  logic          w_to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_to_cnt <= '0;
    else if (r_state != S_WAIT_RESP) r_to_cnt <= '0;
    else                            r_to_cnt <= r_to_cnt + TW'(1);
  end

  assign w_to_hit = (r_state == S_WAIT_RESP) && (r_to_cnt == TW'(TIMEOUT_CYCLES-1));
`else
  logic w_to_hit;
  logic w_unused_timeout;
  assign w_to_hit         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_to_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (nmcu_instr_ready_i) w_state_nxt = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (nmcu_resp_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RETURN;
        end else if (w_to_hit) begin
          w_to_fire   = 1'b1;
          w_state_nxt = S_RETURN;
        end
      end
      S_RETURN: begin
        if (host_resp_ready_i) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{instr: host_instr_i, tag: r_tag_cnt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PW'(1);
        r_tag_cnt <= r_tag_cnt + TAG_WIDTH'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_instr <= '0;
      r_issue_tag   <= '0;
      r_resp        <= '0;
      r_resp_tag    <= '0;
    end else begin
      if (w_pop) begin
        r_issue_instr <= r_mem[r_rd_ptr].instr;
        r_issue_tag   <= r_mem[r_rd_ptr].tag;
      end
      if (w_capture) begin
        r_resp     <= nmcu_response_i;
        r_resp_tag <= r_issue_tag;
      end else if (w_to_fire) begin
        r_resp     <= '{data: '0, status: 2'b11};
        r_resp_tag <= r_issue_tag;
      end
    end
  end

  // Responses are always accepted; outside WAIT_RESP they are dropped so a stuck NMCU cannot stall us.
  assign nmcu_resp_ready_o  = 1'b1;
  assign host_instr_ready_o = !w_full;
  assign host_resp_valid_o  = (r_state == S_RETURN);
  assign host_resp_o        = r_resp;
  assign host_resp_tag_o    = r_resp_tag;
  assign nmcu_instr_valid_o = (r_state == S_ISSUE);
  assign nmcu_instruction_o = r_issue_instr;
  assign busy_o             = (r_state != S_IDLE) || !w_empty;
  assign queue_count_o      = r_count;

endmodule

// File: tb/tb_nmcu_instr_dispatcher.sv
// Directed bench for nmcu_instr_dispatcher; the bench itself plays the NMCU and the host.
module tb_nmcu_instr_dispatcher;
  import instr_pkg::*;

  localparam int DEPTH          = 4;
  localparam int TAG_WIDTH      = 4;
  localparam int TIMEOUT_CYCLES = 50;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   host_instr_valid_i;
  instruction_t           host_instr_i;
  logic                   host_instr_ready_o;
  logic                   host_resp_valid_o;
  logic                   host_resp_ready_i;
  nmcu_cpu_resp_t         host_resp_o;
  logic [TAG_WIDTH-1:0]   host_resp_tag_o;
  logic                   nmcu_instr_valid_o;
  instruction_t           nmcu_instruction_o;
  logic                   nmcu_instr_ready_i;
  logic                   nmcu_resp_valid_i;
  logic                   nmcu_resp_ready_o;
  nmcu_cpu_resp_t         nmcu_response_i;
  logic                   busy_o;
  logic [$clog2(DEPTH+1)-1:0] queue_count_o;

  int n_err = 0;
  int n_chk = 0;

  nmcu_instr_dispatcher #(
    .DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .host_instr_valid_i(host_instr_valid_i), .host_instr_i(host_instr_i),
    .host_instr_ready_o(host_instr_ready_o),
    .host_resp_valid_o(host_resp_valid_o), .host_resp_ready_i(host_resp_ready_i),
    .host_resp_o(host_resp_o), .host_resp_tag_o(host_resp_tag_o),
    .nmcu_instr_valid_o(nmcu_instr_valid_o), .nmcu_instruction_o(nmcu_instruction_o),
    .nmcu_instr_ready_i(nmcu_instr_ready_i),
    .nmcu_resp_valid_i(nmcu_resp_valid_i), .nmcu_resp_ready_o(nmcu_resp_ready_o),
    .nmcu_response_i(nmcu_response_i),
    .busy_o(busy_o), .queue_count_o(queue_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instruction_t mk(input opcode_t op, input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [7:0] n, input logic [7:0] m,
                                      input logic [7:0] k, input logic [31:0] d);
    instruction_t x;
    x.opcode = op; x.addr_a = a; x.addr_b = b; x.addr_c = c;
    x.dim_n = n; x.dim_m = m; x.dim_k = k; x.data = d;
    return x;
  endfunction

  task automatic push(input instruction_t ins);
    host_instr_valid_i = 1'b1;
    host_instr_i       = ins;
    tick();
    host_instr_valid_i = 1'b0;
  endtask

  task automatic wait_issue(input string name, input instruction_t exp_ins);
    int cyc = 0;
    while (!nmcu_instr_valid_o && cyc < 100) begin
      tick();
      cyc++;
    end
    chk({name, "_issued"}, 128'(nmcu_instr_valid_o), 128'(1));
    chk({name, "_instr"}, 128'(nmcu_instruction_o), 128'(exp_ins));
    nmcu_instr_ready_i = 1'b1;
    tick();
    nmcu_instr_ready_i = 1'b0;
    chk({name, "_valid_dropped"}, 128'(nmcu_instr_valid_o), 128'(0));
  endtask

  task automatic respond(input logic [31:0] d, input logic [1:0] s, input int latency);
    repeat (latency) tick();
    nmcu_resp_valid_i = 1'b1;
    nmcu_response_i   = '{data: d, status: s};
    tick();
    nmcu_resp_valid_i = 1'b0;
    nmcu_response_i   = '0;
  endtask

  task automatic expect_resp(input string name, input logic [31:0] d, input logic [1:0] s,
                             input logic [TAG_WIDTH-1:0] t);
    int cyc = 0;
    while (!host_resp_valid_o && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({name, "_resp_valid"}, 128'(host_resp_valid_o), 128'(1));
    chk({name, "_resp_data"}, 128'(host_resp_o.data), 128'(d));
    chk({name, "_resp_status"}, 128'(host_resp_o.status), 128'(s));
    chk({name, "_resp_tag"}, 128'(host_resp_tag_o), 128'(t));
    host_resp_ready_i = 1'b1;
    tick();
    host_resp_ready_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  instruction_t b2b [5];
  instruction_t s1, s6, mm, ld;

  initial begin
    rst = 1'b1;
    host_instr_valid_i = 1'b0; host_instr_i = '0; host_resp_ready_i = 1'b0;
    nmcu_instr_ready_i = 1'b0; nmcu_resp_valid_i = 1'b0; nmcu_response_i = '0;
    repeat (3) tick();

    // reset state, sampled while rst is still high
    chk("rst_instr_valid", 128'(nmcu_instr_valid_o), 128'(0));
    chk("rst_resp_valid", 128'(host_resp_valid_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_count", 128'(queue_count_o), 128'(0));
    chk("rst_ready", 128'(host_instr_ready_o), 128'(1));
    chk("rst_data_out", 128'({host_resp_o, host_resp_tag_o, nmcu_instruction_o}), 128'(0));
    rst = 1'b0;
    tick();

    // single STORE: issue one cycle after the push
    s1 = mk(OP_STORE, 16'd0, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd1);
    push(s1);
    chk("t1_count_after_push", 128'(queue_count_o), 128'(1));
    chk("t1_not_yet_issued", 128'(nmcu_instr_valid_o), 128'(0));
    chk("t1_busy", 128'(busy_o), 128'(1));
    tick();
    chk("t1_issue_1cyc", 128'(nmcu_instr_valid_o), 128'(1));
    chk("t1_count_popped", 128'(queue_count_o), 128'(0));
    wait_issue("t1", s1);
    chk("t1_resp_ready", 128'(nmcu_resp_ready_o), 128'(1));
    respond(32'd0, 2'b00, 5);
    expect_resp("t1", 32'd0, 2'b00, 4'd0);
    chk("t1_idle", 128'(busy_o), 128'(0));

    // back-to-back: 5 pushes, FIFO fills behind the in-flight one
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      b2b[i] = mk(OP_STORE, 16'(i * 4), 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'(i + 10));
      chk("t2_ready_before_push", 128'(host_instr_ready_o), 128'(1));
      host_instr_valid_i = 1'b1;
      host_instr_i       = b2b[i];
      tick();
    end
    chk("t2_full_ready", 128'(host_instr_ready_o), 128'(0));
    chk("t2_full_count", 128'(queue_count_o), 128'(4));
    s6 = mk(OP_STORE, 16'd99, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd99);
    host_instr_i = s6;
    repeat (2) tick();
    chk("t2_refused_count", 128'(queue_count_o), 128'(4));
    wait_issue("t2_0", b2b[0]);
    respond(32'd100, 2'b00, 3);
    chk("t2_0_tag", 128'(host_resp_tag_o), 128'(0));
    chk("t2_0_data", 128'(host_resp_o.data), 128'(100));
    host_resp_ready_i = 1'b1;
    tick();
    host_resp_ready_i = 1'b0;
    // pop on this edge must not admit the held push
    chk("t2_no_passthrough", 128'(queue_count_o), 128'(3));
    host_instr_valid_i = 1'b0;
    chk("t2_direct_reissue", 128'(nmcu_instr_valid_o), 128'(1));
    for (int i = 1; i < 5; i++) begin
      wait_issue("t2_n", b2b[i]);
      respond(32'(100 + i), 2'b00, 2);
      expect_resp("t2_n", 32'(100 + i), 2'b00, 4'(i));
    end
    chk("t2_idle", 128'(busy_o), 128'(0));

    // host backpressure: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C[1][1] at 203 = 3*6+4*8 = 50
    pulse_reset();
    mm = mk(OP_MATMUL, 16'd0, 16'd100, 16'd200, 8'd2, 8'd2, 8'd2, 32'd0);
    ld = mk(OP_LOAD, 16'd203, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd0);
    push(mm);
    push(ld);
    wait_issue("t3_mm", mm);
    respond(32'd0, 2'b00, 10);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t3_hold", 128'({host_resp_valid_o, host_resp_o, host_resp_tag_o, nmcu_instr_valid_o, queue_count_o}),
          128'({1'b1, 32'd0, 2'b00, 4'd0, 1'b0, 3'd1}));
    end
    expect_resp("t3_mm", 32'd0, 2'b00, 4'd0);
    wait_issue("t3_ld", ld);
    respond(32'd50, 2'b00, 4);
    expect_resp("t3_ld", 32'd50, 2'b00, 4'd1);

    // tag wrap: 17 LOADs give tags 0..15 then 0
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      ld = mk(OP_LOAD, 16'(i), 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd0);
      push(ld);
      wait_issue("t4", ld);
      respond(32'(i * 3), 2'b00, 1);
      expect_resp("t4", 32'(i * 3), 2'b00, 4'(i));
    end

    // stray responses in IDLE are dropped
    nmcu_resp_valid_i = 1'b1;
    nmcu_response_i   = '{data: 32'hDEAD, status: 2'b10};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stray_no_resp", 128'({host_resp_valid_o, busy_o, nmcu_resp_ready_o}), 128'({1'b0, 1'b0, 1'b1}));
    end
    nmcu_resp_valid_i = 1'b0;
    nmcu_response_i   = '0;
    ld = mk(OP_LOAD, 16'd7, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd0);
    push(ld);
    wait_issue("t5_after", ld);
    respond(32'd7, 2'b01, 2);
    expect_resp("t5_after", 32'd7, 2'b01, 4'd1);

    // async reset mid-operation discards queue and in-flight work
    for (int i = 0; i < 3; i++) push(mk(OP_LOAD, 16'(i), 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd0));
    chk("t6_count_before_rst", 128'(queue_count_o), 128'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_rst", 128'({queue_count_o, busy_o, nmcu_instr_valid_o}), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("t6_stays_idle", 128'(busy_o), 128'(0));

`ifdef NMCU_DISP_TIMEOUT_EN
    begin
      int cyc = 0;
      ld = mk(OP_LOAD, 16'd5, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd0);
      push(ld);
      wait_issue("t7", ld);
      while (!host_resp_valid_o && cyc < 200) begin
        tick();
        cyc++;
      end
      chk("t7_timeout_cycles", 128'(cyc), 128'(TIMEOUT_CYCLES));
      chk("t7_timeout_resp", 128'({host_resp_o, host_resp_tag_o}), 128'({32'd0, 2'b11, 4'd0}));
      nmcu_resp_valid_i = 1'b1;
      nmcu_response_i   = '{data: 32'h1234, status: 2'b00};
      tick();
      nmcu_resp_valid_i = 1'b0;
      nmcu_response_i   = '0;
      chk("t7_late_dropped", 128'(host_resp_o), 128'({32'd0, 2'b11}));
      host_resp_ready_i = 1'b1;
      tick();
      host_resp_ready_i = 1'b0;
      chk("t7_back_idle", 128'(busy_o), 128'(0));
    end
`else
    ld = mk(OP_LOAD, 16'd5, 16'd0, 16'd0, 8'd1, 8'd0, 8'd0, 32'd0);
    push(ld);
    wait_issue("t7", ld);
    repeat (TIMEOUT_CYCLES + 10) tick();
    chk("t7_waits_forever", 128'({host_resp_valid_o, busy_o}), 128'({1'b0, 1'b1}));
    respond(32'd9, 2'b00, 0);
    expect_resp("t7", 32'd9, 2'b00, 4'd0);
    chk("t7_back_idle", 128'(busy_o), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
